// File: rtl/timx_apb_pkg.sv
// Shared types and constants for the timer APB configuration master.
// FSM encoding, default widths and timer register offsets.
package timx_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 256;

  localparam logic [15:0] REG_CR1  = 16'h0000;
  localparam logic [15:0] REG_SMCR = 16'h0008;
  localparam logic [15:0] REG_CCMR = 16'h0018;
  localparam logic [15:0] REG_CCER = 16'h0020;
  localparam logic [15:0] REG_ARR  = 16'h002C;
  localparam logic [15:0] REG_CNT  = 16'h0038;

  function automatic logic is_aligned(
    input logic [1:0] lsb
  );
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/timx_apb_wdog.sv
// ACCESS-phase wait counter; flags expiry on the last allowed stall cycle.
// Instantiated only when TIMX_APB_TIMEOUT_EN is defined.
module timx_apb_wdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int CW_RAW = $clog2(TIMEOUT_CYCLES);
  localparam int CW =
    (CW_RAW < 8)  ? 8 :
    (CW_RAW > 16) ? 16 : CW_RAW;
  localparam logic [CW-1:0] LAST =
    CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = run & (cnt == LAST);

endmodule

// File: rtl/timx_apb_cfg_master.sv
// Command-stream to APB initiator for the advanced timer register port.
// Optional ACCESS timeout enabled by defining TIMX_APB_TIMEOUT_EN.
module timx_apb_cfg_master
  import timx_apb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic              apb_clk,
  input  logic              apb_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              timx_psel,
  output logic              timx_penable,
  output logic              timx_pwrite,
  output logic [ADDR_W-1:0] timx_paddr,
  output logic [DATA_W-1:0] timx_pwdata,
  input  logic [DATA_W-1:0] timx_prdata,
  input  logic              timx_pready,
  input  logic              timx_pslverr,
  output logic              busy
);

  state_t state;
  logic   live;
  logic   hs;
  logic   aligned;
  logic   expire;
  logic   done;

  // live keeps cmd_ready low while reset is held
  assign cmd_ready = live & (
    (state == IDLE) |
    ((state == RESP) & rsp_ready));

  assign hs      = cmd_valid & cmd_ready;
  assign aligned = is_aligned(cmd_addr[1:0]);
  assign done    = (state == RESP) & rsp_ready;

`ifdef TIMX_APB_TIMEOUT_EN
  timx_apb_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (apb_clk),
    .rst_n  (apb_rst_n),
    .clr    (state == SETUP),
    .run    ((state == ACCESS) & ~timx_pready),
    .expired(expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES[0];
  assign expire = 1'b0;
`endif

  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      state        <= IDLE;
      live         <= 1'b0;
      busy         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= '0;
      timx_psel    <= 1'b0;
      timx_penable <= 1'b0;
      timx_pwrite  <= 1'b0;
      timx_paddr   <= '0;
      timx_pwdata  <= '0;
    end else begin
      live <= 1'b1;
      unique case (state)
        IDLE, RESP: begin
          if (done) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            state     <= IDLE;
            busy      <= 1'b0;
          end
          if (hs && aligned) begin
            state       <= SETUP;
            busy        <= 1'b1;
            timx_psel   <= 1'b1;
            timx_pwrite <= cmd_write;
            timx_paddr  <= cmd_addr;
            timx_pwdata <= cmd_write ?
              cmd_wdata : '0;
          end else if (hs) begin
            // misaligned: answer at once, bus untouched
            state     <= RESP;
            busy      <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        SETUP: begin
          state        <= ACCESS;
          timx_penable <= 1'b1;
        end
        ACCESS: begin
          if (timx_pready) begin
            state        <= RESP;
            timx_psel    <= 1'b0;
            timx_penable <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_err      <= timx_pslverr;
            rsp_rdata    <=
              (timx_pwrite | timx_pslverr) ?
              '0 : timx_prdata;
          end else if (expire) begin
            state        <= RESP;
            timx_psel    <= 1'b0;
            timx_penable <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_err      <= 1'b1;
            rsp_rdata    <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timx_apb_cfg_master.sv
// Directed bench for timx_apb_cfg_master.
// Vector table plus back-to-back, reset and timeout sequences.
module tb_timx_apb_cfg_master;
  import timx_apb_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timx_apb_cfg_master #(
    .ADDR_W(16),
    .DATA_W(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .apb_clk     (clk),
    .apb_rst_n   (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .timx_psel   (psel),
    .timx_penable(penable),
    .timx_pwrite (pwrite),
    .timx_paddr  (paddr),
    .timx_pwdata (pwdata),
    .timx_prdata (prdata),
    .timx_pready (pready),
    .timx_pslverr(pslverr),
    .busy        (busy)
  );

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h",
        nm, act, exp);
    end
  endtask

  task automatic issue(
    input logic        w,
    input logic [15:0] a,
    input logic [31:0] d
  );
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle", {busy, rsp_valid, psel},
      3'b000);
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] ew;
    ew = v.write ? v.wdata : 32'h0;
    rsp_ready = 1'b0;
    prdata = v.prdata;
    issue(v.write, v.addr, v.wdata);
    if (v.addr[1:0] == 2'b00) begin
      chk("setup",
        {psel, penable, busy, pwrite, paddr, pwdata},
        {1'b1, 1'b0, 1'b1, v.write, v.addr, ew});
      for (int k = 0; k <= v.waits; k++) begin
        @(negedge clk);
        chk("access",
          {psel, penable, rsp_valid, pwrite,
           paddr, pwdata},
          {1'b1, 1'b1, 1'b0, v.write,
           v.addr, ew});
        pready  = (k == v.waits);
        pslverr = pready ? v.slverr : 1'b1;
      end
      @(negedge clk);
      pready  = 1'b0;
      pslverr = 1'b0;
    end
    chk("resp",
      {rsp_valid, psel, penable, cmd_ready,
       rsp_err, rsp_rdata},
      {1'b1, 1'b0, 1'b0, 1'b0,
       v.exp_err, v.exp_rdata});
    @(negedge clk);
    chk("hold",
      {rsp_valid, psel, cmd_ready,
       rsp_err, rsp_rdata},
      {1'b1, 1'b0, 1'b0,
       v.exp_err, v.exp_rdata});
    consume();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  initial begin
    logic [15:0] b2b[4];
    int n;
    vecs[0] = '{1'b1, REG_ARR, 32'h0000AA55,
                0, 32'h0BAD0BAD, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, REG_CNT, 32'hFFFFFFFF,
                3, 32'h00001234, 1'b0, 1'b0,
                32'h00001234};
    vecs[2] = '{1'b1, REG_CCMR, 32'h00000011,
                0, 32'h0, 1'b1, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 16'h0002, 32'h0,
                0, 32'h55555555, 1'b0, 1'b1, 32'h0};
    vecs[4] = '{1'b0, REG_CCER, 32'h0,
                1, 32'h0000DEAD, 1'b1, 1'b1, 32'h0};
    vecs[5] = '{1'b0, REG_ARR, 32'h0,
                0, 32'hCAFE0001, 1'b0, 1'b0,
                32'hCAFE0001};
    vecs[6] = '{1'b1, 16'h0003, 32'h12345678,
                2, 32'h0, 1'b0, 1'b1, 32'h0};
    b2b[0] = REG_CCMR;
    b2b[1] = REG_CCER;
    b2b[2] = REG_SMCR;
    b2b[3] = REG_CR1;

    repeat (3) @(negedge clk);
    chk("reset",
      {cmd_ready, rsp_valid, rsp_err, psel,
       penable, pwrite, busy, paddr,
       rsp_rdata},
      '0);
    chk("reset_wd", 64'(pwdata), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
    end

    // back-to-back writes with rsp_ready held high
    @(negedge clk);
    rsp_ready = 1'b1;
    pready    = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = b2b[0];
    cmd_wdata = 32'h100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_setup",
        {psel, penable, paddr, pwdata},
        {1'b1, 1'b0, b2b[i], 32'h100 + i});
      @(negedge clk);
      chk("b2b_access", {psel, penable},
        2'b11);
      @(negedge clk);
      chk("b2b_resp",
        {rsp_valid, psel, cmd_ready, rsp_err},
        4'b1010);
      if (i < 3) begin
        cmd_addr  = b2b[i+1];
        cmd_wdata = 32'h100 + i + 1;
      end else begin
        cmd_valid = 1'b0;
      end
    end
    @(negedge clk);
    pready    = 1'b0;
    rsp_ready = 1'b0;
    chk("b2b_idle", {busy, rsp_valid, psel},
      3'b000);

    // reset asserted in the middle of ACCESS
    issue(1'b0, REG_CNT, 32'h0);
    @(negedge clk);
    chk("pre_rst", {psel, penable}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst",
      {psel, penable, busy, rsp_valid},
      4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst",
      {busy, rsp_valid, psel, cmd_ready},
      4'b0001);

`ifdef TIMX_APB_TIMEOUT_EN
    issue(1'b0, REG_SMCR, 32'h0);
    pready = 1'b0;
    n = 0;
    @(negedge clk);
    while (psel && penable && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("to_len", 64'(n), 64'(TO));
    chk("to_resp",
      {rsp_valid, psel, rsp_err, rsp_rdata},
      {1'b1, 1'b0, 1'b1, 32'h0});
    consume();
`else
    n = 0;
`endif

    $display("CHECKS %0d ERRORS %0d",
      checks, errors);
    $finish;
  end

endmodule
